// File: rtl/seg_ctrl_field.sv
// One field of the digital clock: modulo-MODULO up/down counter with a lock-step
// two-digit BCD copy, synchronous load with range check, and same-cycle carry/borrow.
module seg_ctrl_field #(
    parameter int WIDTH  = 8,
    parameter int MODULO = 60,
    parameter int INIT   = 0
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             cnt_flag,
    input  logic             up_dn,
    input  logic             hold,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic [3:0]       bcd_ones,
    output logic [3:0]       bcd_tens,
    output logic             carry,
    output logic             borrow,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] CNT_MAX   = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] CNT_INIT  = WIDTH'(INIT);
    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULO);
    localparam logic [3:0]       MAX_TENS  = 4'((MODULO - 1) / 10);
    localparam logic [3:0]       MAX_ONES  = 4'((MODULO - 1) % 10);
    localparam logic [3:0]       INIT_TENS = 4'(INIT / 10);
    localparam logic [3:0]       INIT_ONES = 4'(INIT % 10);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]       ones_q, ones_d;
    logic [3:0]       tens_q, tens_d;
    logic             load_err_q, load_err_d;

    logic             tick_en;
    logic             at_max;
    logic             at_zero;
    logic             load_ok;
    logic [MODULO-1:0] val_hit;
    logic [3:0]       load_tens;
    logic [3:0]       load_ones;

    // One comparator per legal value; at most one fires, so OR-ing the
    // constant digit pairs gives the decimal split of load_val without a divider.
    genvar gi;
    generate
        for (gi = 0; gi < MODULO; gi++) begin : g_hit
            assign val_hit[gi] = (load_val == WIDTH'(gi));
        end
    endgenerate

    always_comb begin
        load_tens = 4'd0;
        load_ones = 4'd0;
        for (int i = 0; i < MODULO; i++) begin
            if (val_hit[i]) begin
                load_tens = load_tens | 4'(i / 10);
                load_ones = load_ones | 4'(i % 10);
            end
        end
    end

    assign load_ok = ({1'b0, load_val} < MOD_EXT);
    assign tick_en = cnt_flag & ~hold & ~load;
    assign at_max  = (cnt_q == CNT_MAX);
    assign at_zero = (cnt_q == '0);

    // Gated on the current count only, so these drop with reset through cnt_q.
    assign carry  = tick_en & up_dn & at_max;
    assign borrow = tick_en & ~up_dn & at_zero;

    always_comb begin
        cnt_d      = cnt_q;
        ones_d     = ones_q;
        tens_d     = tens_q;
        load_err_d = 1'b0;
        if (load) begin
            if (load_ok) begin
                cnt_d  = load_val;
                tens_d = load_tens;
                ones_d = load_ones;
            end else begin
                cnt_d      = '0;
                tens_d     = 4'd0;
                ones_d     = 4'd0;
                load_err_d = 1'b1;
            end
        end else if (tick_en) begin
            if (up_dn) begin
                if (at_max) begin
                    cnt_d  = '0;
                    tens_d = 4'd0;
                    ones_d = 4'd0;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                    if (ones_q == 4'd9) begin
                        ones_d = 4'd0;
                        tens_d = tens_q + 4'd1;
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                end
            end else begin
                if (at_zero) begin
                    cnt_d  = CNT_MAX;
                    tens_d = MAX_TENS;
                    ones_d = MAX_ONES;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                    if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q      <= CNT_INIT;
            tens_q     <= INIT_TENS;
            ones_q     <= INIT_ONES;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            load_err_q <= load_err_d;
        end
    end

    assign cnt      = cnt_q;
    assign bcd_tens = tens_q;
    assign bcd_ones = ones_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_seg_ctrl_field.sv
// Bench for seg_ctrl_field: three parameterisations share control inputs and are
// checked every cycle against a modular-arithmetic model plus directed literal checks.
module tb_seg_ctrl_field;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       cnt_flag, up_dn, hold, load;
    logic [7:0] lv0;
    logic [4:0] lv1;
    logic [6:0] lv2;
    logic [7:0] cnt0;
    logic [4:0] cnt1;
    logic [6:0] cnt2;
    logic [3:0] tens [3];
    logic [3:0] ones [3];
    logic       carry [3];
    logic       borrow [3];
    logic       lerr [3];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int m_cnt [3];
    int m_err [3];

    always #5 sys_clk = ~sys_clk;

    seg_ctrl_field #(.WIDTH(8), .MODULO(60), .INIT(0)) u_d0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cnt_flag(cnt_flag), .up_dn(up_dn),
        .hold(hold), .load(load), .load_val(lv0), .cnt(cnt0), .bcd_ones(ones[0]),
        .bcd_tens(tens[0]), .carry(carry[0]), .borrow(borrow[0]), .load_err(lerr[0]));

    seg_ctrl_field #(.WIDTH(5), .MODULO(24), .INIT(12)) u_d1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cnt_flag(cnt_flag), .up_dn(up_dn),
        .hold(hold), .load(load), .load_val(lv1), .cnt(cnt1), .bcd_ones(ones[1]),
        .bcd_tens(tens[1]), .carry(carry[1]), .borrow(borrow[1]), .load_err(lerr[1]));

    seg_ctrl_field #(.WIDTH(7), .MODULO(100), .INIT(0)) u_d2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cnt_flag(cnt_flag), .up_dn(up_dn),
        .hold(hold), .load(load), .load_val(lv2), .cnt(cnt2), .bcd_ones(ones[2]),
        .bcd_tens(tens[2]), .carry(carry[2]), .borrow(borrow[2]), .load_err(lerr[2]));

    function automatic int mod_of(input int i);
        return (i == 0) ? 60 : (i == 1) ? 24 : 100;
    endfunction

    function automatic int init_of(input int i);
        return (i == 1) ? 12 : 0;
    endfunction

    function automatic int lv_of(input int i);
        return (i == 0) ? int'(lv0) : (i == 1) ? int'(lv1) : int'(lv2);
    endfunction

    function automatic int cnt_of(input int i);
        return (i == 0) ? int'(cnt0) : (i == 1) ? int'(cnt1) : int'(cnt2);
    endfunction

    task automatic cmp(input string nm, input int idx, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0d want=%0d t=%0t", nm, idx, act, exp, $time);
        end
    endtask

    // Reference: the count is just an integer in 0..MODULO-1 moved by modular +/-1.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!sys_rst_n) begin
                m_cnt[i] <= init_of(i);
                m_err[i] <= 0;
            end else begin
                m_err[i] <= 0;
                if (load) begin
                    if (lv_of(i) < mod_of(i)) m_cnt[i] <= lv_of(i);
                    else begin
                        m_cnt[i] <= 0;
                        m_err[i] <= 1;
                    end
                end else if (!hold && cnt_flag) begin
                    if (up_dn) m_cnt[i] <= (m_cnt[i] + 1) % mod_of(i);
                    else       m_cnt[i] <= (m_cnt[i] + mod_of(i) - 1) % mod_of(i);
                end
            end
        end
    end

    always @(negedge sys_clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                int  e;
                bit  tk;
                e  = m_cnt[i];
                tk = cnt_flag && !hold && !load;
                cmp("cnt",  i, cnt_of(i),      e);
                cmp("tens", i, int'(tens[i]),  e / 10);
                cmp("ones", i, int'(ones[i]),  e % 10);
                cmp("lerr", i, int'(lerr[i]),  m_err[i]);
                cmp("carry",  i, int'(carry[i]),  int'(tk && up_dn && (e + 1 == mod_of(i))));
                cmp("borrow", i, int'(borrow[i]), int'(tk && !up_dn && (e == 0)));
            end
        end
    end

    task automatic drive(input bit f, input bit u, input bit h, input bit l,
                         input int v0, input int v1, input int v2);
        cnt_flag = f;
        up_dn    = u;
        hold     = h;
        load     = l;
        lv0      = 8'(v0);
        lv1      = 5'(v1);
        lv2      = 7'(v2);
        @(negedge sys_clk);
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        cnt_flag = 0; up_dn = 1; hold = 0; load = 0;
        lv0 = 0; lv1 = 0; lv2 = 0;
        repeat (2) @(posedge sys_clk);
        #1;
        cmp("rst_cnt0", 0, int'(cnt0), 0);
        cmp("rst_cnt1", 1, int'(cnt1), 12);
        cmp("rst_tens1", 1, int'(tens[1]), 1);
        cmp("rst_ones1", 1, int'(ones[1]), 2);
        cmp("rst_lerr0", 0, int'(lerr[0]), 0);
        #2 sys_rst_n = 1'b1;
        step();
        chk_en = 1'b1;

        // 60 up-ticks: carry only on the last one, then back to 0
        for (int k = 0; k < 60; k++) begin
            drive(1, 1, 0, 0, 0, 0, 0);
            cmp("up_cnt", 0, int'(cnt0), k);
            cmp("up_carry", 0, int'(carry[0]), (k == 59) ? 1 : 0);
            step();
        end
        $display("txn up60 cnt0=%0d", cnt0);
        cmp("wrap_cnt", 0, int'(cnt0), 0);

        drive(1, 0, 0, 0, 0, 0, 0);
        cmp("dn_borrow", 0, int'(borrow[0]), 1);
        step();
        cmp("dn_cnt", 0, int'(cnt0), 59);
        cmp("dn_tens", 0, int'(tens[0]), 5);
        cmp("dn_ones", 0, int'(ones[0]), 9);
        repeat (10) begin
            drive(1, 0, 0, 0, 0, 0, 0);
            step();
        end
        $display("txn down11 cnt0=%0d", cnt0);
        cmp("dn10_cnt", 0, int'(cnt0), 49);
        cmp("dn10_tens", 0, int'(tens[0]), 4);
        cmp("dn10_ones", 0, int'(ones[0]), 9);
        cmp("model_pin", 0, m_cnt[0], 49);

        // load beats a simultaneous tick
        drive(1, 1, 0, 1, 37, 5, 50);
        cmp("ld_carry", 0, int'(carry[0]), 0);
        step();
        $display("txn load37 cnt0=%0d", cnt0);
        cmp("ld_cnt", 0, int'(cnt0), 37);
        cmp("ld_tens", 0, int'(tens[0]), 3);
        cmp("ld_ones", 0, int'(ones[0]), 7);
        cmp("ld_err", 0, int'(lerr[0]), 0);
        drive(0, 1, 0, 1, 75, 5, 50);
        step();
        $display("txn load75 cnt0=%0d err=%0b", cnt0, lerr[0]);
        cmp("bad_cnt", 0, int'(cnt0), 0);
        cmp("bad_err", 0, int'(lerr[0]), 1);
        drive(0, 1, 0, 0, 0, 0, 0);
        step();
        cmp("bad_err_clr", 0, int'(lerr[0]), 0);

        // hold at 59 suppresses both the tick and the carry
        drive(0, 1, 0, 1, 59, 3, 40);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 1, 0, 0, 0, 0);
            cmp("hold_carry", 0, int'(carry[0]), 0);
            step();
            cmp("hold_cnt", 0, int'(cnt0), 59);
        end
        drive(1, 1, 0, 0, 0, 0, 0);
        cmp("rel_carry", 0, int'(carry[0]), 1);
        step();
        $display("txn hold_release cnt0=%0d", cnt0);
        cmp("rel_cnt", 0, int'(cnt0), 0);

        // wraps of the 24 and 100 instances
        drive(0, 1, 0, 1, 10, 23, 99);
        step();
        drive(1, 1, 0, 0, 0, 0, 0);
        cmp("w24_carry", 1, int'(carry[1]), 1);
        cmp("w100_carry", 2, int'(carry[2]), 1);
        step();
        cmp("w24_up", 1, int'(cnt1), 0);
        cmp("w100_up", 2, int'(cnt2), 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        cmp("w24_borrow", 1, int'(borrow[1]), 1);
        cmp("w100_borrow", 2, int'(borrow[2]), 1);
        step();
        $display("txn sweep cnt1=%0d cnt2=%0d", cnt1, cnt2);
        cmp("w24_dn", 1, int'(cnt1), 23);
        cmp("w24_tens", 1, int'(tens[1]), 2);
        cmp("w24_ones", 1, int'(ones[1]), 3);
        cmp("w100_dn", 2, int'(cnt2), 99);
        cmp("w100_tens", 2, int'(tens[2]), 9);
        cmp("w100_ones", 2, int'(ones[2]), 9);

        // randomized traffic checked by the model every cycle
        for (int k = 0; k < 1500; k++) begin
            drive(($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 127)));
            $display("txn %0d f=%0b u=%0b h=%0b l=%0b cnt=%0d/%0d/%0d", k, cnt_flag, up_dn,
                     hold, load, cnt0, cnt1, cnt2);
            step();
        end

        // asynchronous reset mid-count
        drive(0, 1, 0, 1, 42, 7, 42);
        step();
        cmp("pre_rst_cnt", 0, int'(cnt0), 42);
        cnt_flag = 1; up_dn = 1; hold = 0; load = 0;
        #2 sys_rst_n = 1'b0;
        #1;
        cmp("arst_cnt0", 0, int'(cnt0), 0);
        cmp("arst_tens0", 0, int'(tens[0]), 0);
        cmp("arst_ones0", 0, int'(ones[0]), 0);
        cmp("arst_err0", 0, int'(lerr[0]), 0);
        cmp("arst_cnt1", 1, int'(cnt1), 12);
        @(posedge sys_clk);
        #2 sys_rst_n = 1'b1;
        step();
        $display("txn arst_resume cnt0=%0d cnt1=%0d", cnt0, cnt1);
        cmp("resume_cnt0", 0, int'(cnt0), 1);
        cmp("resume_cnt1", 1, int'(cnt1), 13);
        drive(0, 1, 0, 0, 0, 0, 0);
        step();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
